// File: rtl/hazard_detection_unit.sv
// Load-use / taken-branch hazard control for the ID stage, with saturating stall and flush counters.
// Optional `MULDIV_STALL_EN adds mul_busy_i and an MD_WAIT state that holds the front end while EXE is busy.
module hazard_detection_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_use_rs1_i,
  input  logic             ID_use_rs2_i,
  input  logic [4:0]       EXE_rd_i,
  input  logic             EXE_MemRead_i,
  input  logic             branch_taken_i,
`ifdef MULDIV_STALL_EN
  input  logic             mul_busy_i,
`endif
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEXE_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] STALL   = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;
`ifdef MULDIV_STALL_EN
  localparam logic [1:0] MD_WAIT = 2'd3;
`endif

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state, next_state;
  logic [2:0] remaining, next_remaining;
  logic       load_use;
  logic       run_like;
  logic       stall_evt;
  logic       branch_acc;
  logic       pc_write, ifid_write, ifid_flush, idexe_bubble;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign load_use = EXE_MemRead_i && (EXE_rd_i != 5'd0) &&
                    ((ID_use_rs1_i && (EXE_rd_i == ID_rs1_i)) ||
                     (ID_use_rs2_i && (EXE_rd_i == ID_rs2_i)));

  always_comb begin
    run_like = (state == RUN) || (state == STALL);
`ifdef MULDIV_STALL_EN
    if (state == MD_WAIT && !mul_busy_i)
      run_like = 1'b1;
`endif
  end

  always_comb begin
    next_state     = state;
    next_remaining = remaining;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idexe_bubble   = 1'b0;
    stall_evt      = 1'b0;
    branch_acc     = 1'b0;

    if (state == FLUSH) begin
      // The instruction in ID is being squashed, so its operands are irrelevant.
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
      if (branch_taken_i) begin
        branch_acc     = 1'b1;
        next_remaining = FLUSH_RELOAD;
        next_state     = (FLUSH_RELOAD == 3'd0) ? RUN : FLUSH;
      end else if (remaining <= 3'd1) begin
        next_remaining = 3'd0;
        next_state     = RUN;
      end else begin
        next_remaining = remaining - 3'd1;
      end
    end else if (run_like) begin
      // Branch beats everything: a squashed instruction needs no stall.
      if (branch_taken_i) begin
        ifid_flush     = 1'b1;
        idexe_bubble   = 1'b1;
        branch_acc     = 1'b1;
        next_remaining = FLUSH_RELOAD;
        next_state     = (FLUSH_RELOAD == 3'd0) ? RUN : FLUSH;
`ifdef MULDIV_STALL_EN
      end else if (mul_busy_i) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        stall_evt  = 1'b1;
        next_state = MD_WAIT;
`endif
      end else if (load_use) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idexe_bubble = 1'b1;
        stall_evt    = 1'b1;
        next_state   = STALL;
      end else begin
        next_state = RUN;
      end
`ifdef MULDIV_STALL_EN
    end else if (state == MD_WAIT) begin
      // EXE keeps its multi-cycle op, so no bubble is injected behind it.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      stall_evt  = 1'b1;
`endif
    end else begin
      next_state = RUN;
    end
  end

  always_comb begin
    PC_write_o     = pc_write;
    IFID_write_o   = ifid_write;
    IFID_flush_o   = ifid_flush;
    IDEXE_bubble_o = idexe_bubble;
    if (rst_i) begin
      PC_write_o     = 1'b1;
      IFID_write_o   = 1'b1;
      IFID_flush_o   = 1'b0;
      IDEXE_bubble_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      remaining <= 3'd0;
    end else begin
      state     <= next_state;
      remaining <= next_remaining;
    end
  end

  // Performance counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_evt && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (branch_acc && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule
